// File: rtl/gemm_seq_ctrl_if.sv
// Bundles the DMA stream and src/MAC/dst datapath signals driven or observed by the GEMM sequencer.
// The master side is the sequencer; the slave side is the DMA shim plus buffers and MAC.
interface gemm_seq_ctrl_if #(
   parameter int SRC_WORDS = 16,
   parameter int DST_WORDS = 8
);
   localparam int SA_W = $clog2(SRC_WORDS);
   localparam int IA_W = $clog2(2 * SRC_WORDS);
   localparam int OA_W = $clog2(2 * DST_WORDS);
   localparam int DA_W = $clog2(DST_WORDS);

   logic            s_valid;
   logic            s_ready;
   logic [63:0]     s_data;

   logic            m_valid;
   logic            m_ready;
   logic [63:0]     m_data;
   logic            m_last;

   logic            src_v;
   logic [SA_W-1:0] src_a;
   logic [63:0]     src_d;

   logic            exec;
   logic [IA_W-1:0] ia;
   logic            acc_first;

   logic            outr;
   logic [OA_W-1:0] oa;

   logic            dst_v;
   logic [DA_W-1:0] dst_a;
   logic [63:0]     dst_d;

   modport master (
      input  s_valid, s_data, m_ready, dst_d,
      output s_ready, m_valid, m_data, m_last,
             src_v, src_a, src_d, exec, ia, acc_first, outr, oa, dst_v, dst_a
   );

   modport slave (
      output s_valid, s_data, m_ready, dst_d,
      input  s_ready, m_valid, m_data, m_last,
             src_v, src_a, src_d, exec, ia, acc_first, outr, oa, dst_v, dst_a
   );
endinterface

// File: rtl/gemm_seq_ctrl.sv
// One GEMM tile pass: load src buffer from DMA, sweep operands through the MAC,
// retire results into dst buffer, then stream dst buffer back out to DMA.
module gemm_seq_ctrl #(
   parameter int SRC_WORDS = 16,
   parameter int DST_WORDS = 8,
   parameter int KLEN      = 2,
   parameter int MAC_LAT   = 2
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            start,
   output logic            busy,
   output logic            done,
   gemm_seq_ctrl_if.master bus
);
   localparam int SA_W = $clog2(SRC_WORDS);
   localparam int IA_W = $clog2(2 * SRC_WORDS);
   localparam int OA_W = $clog2(2 * DST_WORDS);
   localparam int DA_W = $clog2(DST_WORDS);
   localparam int RC_W = $clog2(DST_WORDS + 1);
   localparam int KC_W = (KLEN > 1) ? $clog2(KLEN) : 1;

   localparam logic [SA_W-1:0] LD_LAST   = SA_W'(SRC_WORDS - 1);
   localparam logic [IA_W-1:0] IA_LAST   = IA_W'(2 * SRC_WORDS - 1);
   localparam logic [OA_W-1:0] GRP_LAST  = OA_W'(2 * DST_WORDS - 1);
   localparam logic [KC_W-1:0] K_LAST    = KC_W'(KLEN - 1);
   localparam logic [RC_W-1:0] RD_END    = RC_W'(DST_WORDS);
   localparam logic [DA_W-1:0] BEAT_LAST = DA_W'(DST_WORDS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_EXEC,
      S_DRAIN,
      S_STORE
   } state_t;

   state_t                       state_q, state_d;
   logic [SA_W-1:0]              ld_cnt_q, ld_cnt_d;
   logic [IA_W-1:0]              ia_q, ia_d;
   logic [KC_W-1:0]              k_q, k_d;
   logic [OA_W-1:0]              grp_q, grp_d;
   logic [MAC_LAT-1:0]           pipe_v_q, pipe_v_d;
   logic [MAC_LAT-1:0][OA_W-1:0] pipe_g_q, pipe_g_d;
   logic [RC_W-1:0]              rd_cnt_q, rd_cnt_d;
   logic [DA_W-1:0]              beat_q, beat_d;
   logic                         m_valid_q, m_valid_d;
   logic                         done_q, done_d;

   logic exec_on;
   logic s_fire;
   logic grp_end;
   logic res_v;
   logic dst_rd;
   logic m_fire;
   logic last_fire;

   assign exec_on   = (state_q == S_EXEC);
   assign s_fire    = (state_q == S_LOAD) && bus.s_valid;
   assign grp_end   = exec_on && (k_q == K_LAST);
   assign res_v     = pipe_v_q[MAC_LAT-1];
   // A new buffer read is only issued when the output register is empty or being drained this cycle.
   assign dst_rd    = (state_q == S_STORE) && (rd_cnt_q < RD_END) && (!m_valid_q || bus.m_ready);
   assign m_fire    = m_valid_q && bus.m_ready;
   assign last_fire = m_fire && (beat_q == BEAT_LAST);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= S_IDLE;
         ld_cnt_q  <= '0;
         ia_q      <= '0;
         k_q       <= '0;
         grp_q     <= '0;
         pipe_v_q  <= '0;
         pipe_g_q  <= '0;
         rd_cnt_q  <= '0;
         beat_q    <= '0;
         m_valid_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         ld_cnt_q  <= ld_cnt_d;
         ia_q      <= ia_d;
         k_q       <= k_d;
         grp_q     <= grp_d;
         pipe_v_q  <= pipe_v_d;
         pipe_g_q  <= pipe_g_d;
         rd_cnt_q  <= rd_cnt_d;
         beat_q    <= beat_d;
         m_valid_q <= m_valid_d;
         done_q    <= done_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      ld_cnt_d  = ld_cnt_q;
      ia_d      = ia_q;
      k_d       = k_q;
      grp_d     = grp_q;
      pipe_v_d  = pipe_v_q;
      pipe_g_d  = pipe_g_q;
      rd_cnt_d  = rd_cnt_q;
      beat_d    = beat_q;
      m_valid_d = m_valid_q;
      done_d    = 1'b0;

      // Group-end marks ride a MAC_LAT-deep delay line so outr lines up with the MAC result.
      pipe_v_d[0] = grp_end;
      pipe_g_d[0] = grp_q;
      for (int i = 1; i < MAC_LAT; i++) begin
         pipe_v_d[i] = pipe_v_q[i-1];
         pipe_g_d[i] = pipe_g_q[i-1];
      end

      if (dst_rd) begin
         m_valid_d = 1'b1;
      end else if (bus.m_ready) begin
         m_valid_d = 1'b0;
      end

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d  = S_LOAD;
               ld_cnt_d = '0;
               ia_d     = '0;
               k_d      = '0;
               grp_d    = '0;
               rd_cnt_d = '0;
               beat_d   = '0;
            end
         end
         S_LOAD: begin
            if (s_fire) begin
               ld_cnt_d = ld_cnt_q + 1'b1;
               if (ld_cnt_q == LD_LAST) begin
                  state_d  = S_EXEC;
                  ld_cnt_d = '0;
               end
            end
         end
         S_EXEC: begin
            ia_d = ia_q + 1'b1;
            if (k_q == K_LAST) begin
               k_d   = '0;
               grp_d = grp_q + 1'b1;
            end else begin
               k_d = k_q + 1'b1;
            end
            if (ia_q == IA_LAST) begin
               state_d = S_DRAIN;
               ia_d    = '0;
               k_d     = '0;
               grp_d   = '0;
            end
         end
         S_DRAIN: begin
            if (res_v && (pipe_g_q[MAC_LAT-1] == GRP_LAST)) begin
               state_d = S_STORE;
            end
         end
         S_STORE: begin
            if (dst_rd) begin
               rd_cnt_d = rd_cnt_q + 1'b1;
               beat_d   = rd_cnt_q[DA_W-1:0];
            end
            if (last_fire) begin
               state_d  = S_IDLE;
               done_d   = 1'b1;
               rd_cnt_d = '0;
               beat_d   = '0;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign busy          = (state_q != S_IDLE);
   assign done          = done_q;

   assign bus.s_ready   = (state_q == S_LOAD);
   assign bus.src_v     = s_fire;
   assign bus.src_a     = s_fire ? ld_cnt_q : '0;
   assign bus.src_d     = bus.s_data;

   assign bus.exec      = exec_on;
   assign bus.ia        = exec_on ? ia_q : '0;
   assign bus.acc_first = exec_on && (k_q == '0);

   assign bus.outr      = res_v;
   assign bus.oa        = res_v ? pipe_g_q[MAC_LAT-1] : '0;

   assign bus.dst_v     = dst_rd;
   assign bus.dst_a     = dst_rd ? rd_cnt_q[DA_W-1:0] : '0;

   assign bus.m_valid   = m_valid_q;
   assign bus.m_data    = bus.dst_d;
   assign bus.m_last    = m_valid_q && (beat_q == BEAT_LAST);
endmodule

// File: tb/tb_gemm_seq_ctrl.sv
// Directed bench for gemm_seq_ctrl: reset/abort, load with gaps, exec/outr timing,
// store with and without backpressure, and start pulses that must be ignored.
module tb_gemm_seq_ctrl;
   localparam int SRC_WORDS = 16;
   localparam int DST_WORDS = 8;
   localparam int KLEN      = 2;
   localparam int MAC_LAT   = 2;
   localparam int LOGN      = 512;

   logic clk     = 1'b0;
   logic reset_n = 1'b0;
   logic start   = 1'b0;
   logic busy;
   logic done;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   gemm_seq_ctrl_if #(.SRC_WORDS(SRC_WORDS), .DST_WORDS(DST_WORDS)) bus ();

   gemm_seq_ctrl #(
      .SRC_WORDS(SRC_WORDS),
      .DST_WORDS(DST_WORDS),
      .KLEN     (KLEN),
      .MAC_LAT  (MAC_LAT)
   ) dut (
      .clk    (clk),
      .reset_n(reset_n),
      .start  (start),
      .busy   (busy),
      .done   (done),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [63:0] src_word(input int i);
      return {32'hC0DE0000, 32'(i)};
   endfunction

   function automatic logic [63:0] dst_word(input int i);
      return {32'hDA7A0000 + 32'(i), 32'h5EED0000 + 32'(i * 7)};
   endfunction

   // dst buffer model: registered one-cycle read
   logic [63:0] dst_mem [DST_WORDS];
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) bus.dst_d <= '0;
      else if (bus.dst_v) bus.dst_d <= dst_mem[bus.dst_a];
   end

   // event logs, appended at the falling edge
   int          src_n = 0, ex_n = 0, or_n = 0, dv_n = 0, hs_n = 0, done_n = 0, viol_n = 0;
   int          src_a_log [LOGN], src_cyc [LOGN];
   logic [63:0] src_d_log [LOGN];
   int          ex_ia [LOGN], ex_af [LOGN], ex_cyc [LOGN];
   int          or_oa [LOGN], or_cyc [LOGN];
   int          dv_a [LOGN], dv_cyc [LOGN];
   logic [63:0] hs_data [LOGN];
   int          hs_last [LOGN], hs_cyc [LOGN];
   int          done_cyc [LOGN];
   logic        prev_stall = 1'b0;
   logic [63:0] prev_data = '0;

   always @(negedge clk) begin
      if (reset_n) begin
         if (bus.src_v && src_n < LOGN) begin
            src_a_log[src_n] <= int'(bus.src_a);
            src_d_log[src_n] <= bus.src_d;
            src_cyc[src_n]   <= cyc;
            src_n            <= src_n + 1;
         end
         if (bus.exec && ex_n < LOGN) begin
            ex_ia[ex_n]  <= int'(bus.ia);
            ex_af[ex_n]  <= int'(bus.acc_first);
            ex_cyc[ex_n] <= cyc;
            ex_n         <= ex_n + 1;
         end
         if (bus.outr && or_n < LOGN) begin
            or_oa[or_n]  <= int'(bus.oa);
            or_cyc[or_n] <= cyc;
            or_n         <= or_n + 1;
         end
         if (bus.dst_v && dv_n < LOGN) begin
            dv_a[dv_n]   <= int'(bus.dst_a);
            dv_cyc[dv_n] <= cyc;
            dv_n         <= dv_n + 1;
         end
         if (bus.m_valid && bus.m_ready && hs_n < LOGN) begin
            hs_data[hs_n] <= bus.m_data;
            hs_last[hs_n] <= int'(bus.m_last);
            hs_cyc[hs_n]  <= cyc;
            hs_n          <= hs_n + 1;
         end
         if (done && done_n < LOGN) begin
            done_cyc[done_n] <= cyc;
            done_n           <= done_n + 1;
         end
         viol_n <= viol_n
                 + int'(bus.src_v && bus.exec)
                 + int'(bus.outr && bus.dst_v)
                 + int'(bus.dst_v && bus.m_valid && !bus.m_ready)
                 + int'(prev_stall && bus.m_valid && (bus.m_data !== prev_data));
         prev_stall <= bus.m_valid && !bus.m_ready;
         prev_data  <= bus.m_data;
      end else begin
         prev_stall <= 1'b0;
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] outs_vec();
      return 64'({busy, done, bus.s_ready, bus.m_valid, bus.m_last, bus.src_v, bus.exec,
                  bus.acc_first, bus.outr, bus.dst_v, bus.src_a, bus.ia, bus.oa, bus.dst_a});
   endfunction

   task automatic do_start();
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      check("busy_after_start", busy, 1);
   endtask

   task automatic do_load(input bit glitch);
      int acc = 0;
      int k   = 0;
      while (acc < SRC_WORDS && k < 200) begin
         bus.s_valid = (k % 3 != 2);
         bus.s_data  = src_word(acc);
         start       = glitch && (k == 4);
         @(negedge clk);
         if (bus.s_valid && bus.s_ready) acc++;
         @(posedge clk);
         #1;
         k++;
      end
      bus.s_valid = 1'b0;
      start       = 1'b0;
      check("load_beats", acc, SRC_WORDS);
   endtask

   task automatic wait_done(input bit bp, input bit glitch);
      int j      = 0;
      int d0     = done_n;
      int dv0    = dv_n;
      bit pulsed = 1'b0;
      while (done_n == d0 && j < 400) begin
         bus.m_ready = bp ? (j % 3 == 0) : 1'b1;
         if (glitch && !pulsed && dv_n > dv0) begin
            start  = 1'b1;
            pulsed = 1'b1;
         end else begin
            start = 1'b0;
         end
         @(posedge clk);
         #1;
         j++;
      end
      start = 1'b0;
      check("done_seen", done_n - d0, 1);
      bus.m_ready = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check("single_done", done_n - d0, 1);
      check("idle_after_done", busy, 0);
      if (glitch) check("glitch_in_store", pulsed, 1);
   endtask

   task automatic check_pass(input int sb, input int eb, input int ob, input int db,
                             input int hb, input int d0, input int vb, input bit bp);
      check("src_count", src_n - sb, SRC_WORDS);
      for (int i = 0; i < SRC_WORDS; i++) begin
         check($sformatf("src_a[%0d]", i), src_a_log[sb+i], i);
         check($sformatf("src_d[%0d]", i), src_d_log[sb+i], src_word(i));
      end
      check("exec_count", ex_n - eb, 2 * SRC_WORDS);
      check("exec_follows_load", ex_cyc[eb], src_cyc[sb+SRC_WORDS-1] + 1);
      for (int i = 0; i < 2 * SRC_WORDS; i++) begin
         check($sformatf("ia[%0d]", i), ex_ia[eb+i], i);
         check($sformatf("acc_first[%0d]", i), ex_af[eb+i], (i % KLEN == 0) ? 1 : 0);
         check($sformatf("exec_cyc[%0d]", i), ex_cyc[eb+i], ex_cyc[eb] + i);
      end
      check("outr_count", or_n - ob, 2 * DST_WORDS);
      for (int g = 0; g < 2 * DST_WORDS; g++) begin
         check($sformatf("oa[%0d]", g), or_oa[ob+g], g);
         check($sformatf("outr_cyc[%0d]", g), or_cyc[ob+g],
               ex_cyc[eb] + KLEN * g + (KLEN - 1) + MAC_LAT);
      end
      check("dst_v_count", dv_n - db, DST_WORDS);
      check("hs_count", hs_n - hb, DST_WORDS);
      for (int i = 0; i < DST_WORDS; i++) begin
         check($sformatf("dst_a[%0d]", i), dv_a[db+i], i);
         check($sformatf("m_data[%0d]", i), hs_data[hb+i], dst_word(i));
         check($sformatf("m_last[%0d]", i), hs_last[hb+i], (i == DST_WORDS - 1) ? 1 : 0);
         if (!bp) begin
            check($sformatf("dst_v_cyc[%0d]", i), dv_cyc[db+i], or_cyc[ob+2*DST_WORDS-1] + 1 + i);
            check($sformatf("hs_cyc[%0d]", i), hs_cyc[hb+i], dv_cyc[db+i] + 1);
         end
      end
      check("done_cyc", done_cyc[d0], hs_cyc[hb+DST_WORDS-1] + 1);
      check("protocol_violations", viol_n - vb, 0);
   endtask

   task automatic run_pass(input bit bp, input bit glitch);
      int sb = src_n;
      int eb = ex_n;
      int ob = or_n;
      int db = dv_n;
      int hb = hs_n;
      int d0 = done_n;
      int vb = viol_n;
      do_start();
      do_load(glitch);
      wait_done(bp, glitch);
      check_pass(sb, eb, ob, db, hb, d0, vb, bp);
   endtask

   initial begin
      int eb;
      int d0;
      int j;
      for (int i = 0; i < DST_WORDS; i++) dst_mem[i] = dst_word(i);
      bus.s_valid = 1'b0;
      bus.s_data  = '0;
      bus.m_ready = 1'b0;

      // power-on reset
      reset_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_outputs", outs_vec(), 0);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      check("idle_not_busy", busy, 0);

      // abort mid-EXEC
      eb = ex_n;
      d0 = done_n;
      do_start();
      do_load(1'b0);
      j = 0;
      while ((ex_n - eb) < 10 && j < 100) begin
         @(posedge clk);
         #1;
         j++;
      end
      check("abort_reached_exec", ((ex_n - eb) >= 10) ? 1 : 0, 1);
      #2;
      reset_n = 1'b0;
      #1;
      check("abort_outputs_zero", outs_vec(), 0);
      repeat (2) @(posedge clk);
      #3;
      reset_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("abort_no_done", done_n - d0, 0);
      check("abort_idle", busy, 0);

      // full pass, no backpressure
      run_pass(1'b0, 1'b0);

      // full pass with backpressure and stray start pulses in LOAD and STORE
      run_pass(1'b1, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
